butterfly_r2_pipe: RTL and testbench
====================================

Name: butterfly_r2_pipe

Overview:
- Parametrised radix-2 DIT butterfly for the oscilloscope FFT datapath. It is the successor to the fixed 16-bit, 2-stage butterfly.
- Computes yp = xp + xq·W and yq = xp − xq·W.
- Adds the following over the earlier block:
  - valid/ready handshake with backpressure;
  - forward/inverse mode (conjugated twiddle);
  - per-stage optional divide-by-2 scaling;
  - round-half-up;
  - saturation with a sticky overflow flag;
  - a sideband tag carried through the pipeline.
- Sits between the FFT stage sample RAM and its write-back address generator.

Parameters:
- DATA_WIDTH, 16, width of each signed real/imag sample, in and out.
- TW_WIDTH, 15, width of each signed twiddle component.
- TW_FRAC, 13, fractional bits of the twiddle (unity = 2^13 = 8192).
- TAG_WIDTH, 10, width of the sideband tag (sample address) passed alongside the data.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts operands this cycle
- inverse  in  1  1 = conjugate twiddle (IFFT); sampled with the operands
- scale  in  1  1 = divide results by 2; sampled with the operands
- in_tag  in  TAG_WIDTH  sideband tag
- xp_real, xp_imag  in  DATA_WIDTH each  signed Xm(p)
- xq_real, xq_imag  in  DATA_WIDTH each  signed Xm(q)
- factor_real, factor_imag  in  TW_WIDTH each  signed twiddle, Q(TW_WIDTH−TW_FRAC).TW_FRAC
- out_valid  out  1  results valid
- out_ready  in  1  downstream accepts results
- out_tag  out  TAG_WIDTH  tag aligned with results
- yp_real, yp_imag, yq_real, yq_imag  out  DATA_WIDTH each  signed results
- ovf_sticky  out  1  set when any result saturated since the last clear
- ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Clock and reset: single clock domain clk. rst_n is asynchronous, active-low.
  - Reset clears all stage valids, all data/tag registers, out_valid, and ovf_sticky to 0.
  - Reset asserted mid-operation discards in-flight operands; no partial output is produced.
- Pipeline: three register stages.
  - S1 holds the four products plus xp<<TW_FRAC, tag, inverse and scale.
  - S2 holds the sums and differences.
  - S3 is the output register after rounding, scaling and saturation.
- Handshake:
  - adv = ~out_valid | out_ready; all stages shift together when adv = 1 and hold otherwise.
  - in_ready = adv (combinational).
  - Accept occurs when in_valid & in_ready. Bubbles propagate as valid = 0.
- Latency and throughput:
  - Latency is exactly 3 cycles from accept to out_valid when out_ready stays high.
  - Throughput is 1 butterfly per cycle.
- Output stability: while out_valid = 1 and out_ready = 0, every output and out_tag holds stable.
- Complex multiply, with wr = factor_real and wi = factor_imag (inverse flips the sign of wi):
  - Forward, inverse = 0:
    - mr = xq_r·wr − xq_i·wi
    - mi = xq_r·wi + xq_i·wr
  - Inverse, inverse = 1:
    - mr = xq_r·wr + xq_i·wi
    - mi = xq_i·wr − xq_r·wi
- Sums: full precision width DATA_WIDTH + TW_WIDTH + 2, so no wrap is possible inside the block.
  - pr = (xp_r << TW_FRAC) + mr
  - qr = (xp_r << TW_FRAC) − mr
  - Imaginary parts likewise.
- Output scaling and rounding:
  - sh = TW_FRAC + scale.
  - result = (sum + 2^(sh−1)) >>> sh, an arithmetic shift (round half toward +∞).
- Saturation:
  - Results are clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Any clamp on any of the four results of an accepted butterfly sets ovf_sticky in the same cycle that out_valid rises for it.
- ovf_sticky clear:
  - ovf_clr clears the flag.
  - If ovf_clr and a new saturation event occur in the same cycle, set wins.
- Boundary conditions:
  - Twiddle −8192 with any xq must not overflow internally.
  - inverse and scale are per-operand and travel with the data; changing them between consecutive accepts has no effect on operands already in flight.

Decomposition:
- Shared package fft_pkg holds:
  - default widths (DATA_WIDTH, TW_WIDTH, TW_FRAC);
  - the unity twiddle constant 2^TW_FRAC;
  - the saturation min/max localparams derived from DATA_WIDTH.
- One natural sub-module, fft_round_sat: rounds, shifts by TW_FRAC + scale, saturates and reports overflow. It is instantiated four times at S2→S3.

Test Plan:
- Identity twiddle: W = (8192, 0), xp = (100, 20), xq = (50, −10), scale = 0 → yp = (150, 10), yq = (50, 30); out_valid exactly 3 cycles after accept; out_tag = in_tag.
- Twiddle −j: W = (0, −8192), xq = (1000, 0), xp = (0, 0), inverse = 0 → yp = (0, −1000), yq = (0, 1000). The same operands with inverse = 1 → yp = (0, 1000), yq = (0, −1000).
- Saturation and sticky flag:
  - xp = (30000, 0), xq = (30000, 0), W = 8192, scale = 0 → yp_real = 32767, yq_real = 0, ovf_sticky = 1.
  - Repeat with scale = 1 → yp_real = 30000, no new overflow.
  - Pulse ovf_clr → flag returns to 0.
- Rounding, W = 8192, xq = 0, scale = 1:
  - xp_real = 3 → 2.
  - xp_real = −3 → −1.
  - xp_real = −32768 → −16384.
- Backpressure: 20 back-to-back accepts with random tags; hold out_ready = 0 for 5 cycles mid-stream → in_ready falls in the same cycle; outputs hold stable; all 20 results emerge in order, with no loss or duplication.
- Reset mid-stream: assert rst_n = 0 with 3 butterflies in flight → out_valid = 0 and ovf_sticky = 0 immediately; after release, the first new accept appears 3 cycles later with correct values.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, unity twiddle and saturation limits for the FFT datapath
package fft_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int TW_WIDTH   = 15;
  localparam int TW_FRAC    = 13;
  localparam int TW_UNITY   = 1 << TW_FRAC;

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(DATA_WIDTH);
  localparam longint SAT_MIN = sat_min(DATA_WIDTH);

endpackage

// File: rtl/fft_round_sat.sv
// rtl/fft_round_sat.sv - round half up, shift by FRAC (+1 when scaling), saturate, flag clamp
module fft_round_sat
  import fft_pkg::*;
#(
  parameter int IN_W  = DATA_WIDTH + TW_WIDTH + 2,
  parameter int OUT_W = DATA_WIDTH,
  parameter int FRAC  = TW_FRAC
) (
  input  logic [IN_W-1:0]  sum,
  input  logic             scale,
  output logic [OUT_W-1:0] result,
  output logic             ovf
);

  localparam logic signed [IN_W:0] HI    = (IN_W + 1)'(sat_max(OUT_W));
  localparam logic signed [IN_W:0] LO    = (IN_W + 1)'(sat_min(OUT_W));
  localparam logic signed [IN_W:0] HALF0 = (IN_W + 1)'(longint'(1) <<< (FRAC - 1));
  localparam logic signed [IN_W:0] HALF1 = (IN_W + 1)'(longint'(1) <<< FRAC);

  // One guard bit so adding the rounding constant can never wrap.
  logic signed [IN_W:0] wide;
  logic signed [IN_W:0] biased;
  logic signed [IN_W:0] shifted;

  assign wide    = {sum[IN_W-1], sum};
  assign biased  = wide + (scale ? HALF1 : HALF0);
  assign shifted = scale ? (biased >>> (FRAC + 1)) : (biased >>> FRAC);

  always_comb begin
    ovf    = 1'b0;
    result = shifted[OUT_W-1:0];
    if (shifted > HI) begin
      result = HI[OUT_W-1:0];
      ovf    = 1'b1;
    end else if (shifted < LO) begin
      result = LO[OUT_W-1:0];
      ovf    = 1'b1;
    end
  end

endmodule

// File: rtl/butterfly_r2_pipe.sv
// rtl/butterfly_r2_pipe.sv - 3-stage radix-2 DIT butterfly with handshake, inverse mode, scaling and saturation
module butterfly_r2_pipe #(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
  parameter int TW_WIDTH   = fft_pkg::TW_WIDTH,
  parameter int TW_FRAC    = fft_pkg::TW_FRAC,
  parameter int TAG_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  inverse,
  input  logic                  scale,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [DATA_WIDTH-1:0] xp_real,
  input  logic [DATA_WIDTH-1:0] xp_imag,
  input  logic [DATA_WIDTH-1:0] xq_real,
  input  logic [DATA_WIDTH-1:0] xq_imag,
  input  logic [TW_WIDTH-1:0]   factor_real,
  input  logic [TW_WIDTH-1:0]   factor_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [DATA_WIDTH-1:0] yp_real,
  output logic [DATA_WIDTH-1:0] yp_imag,
  output logic [DATA_WIDTH-1:0] yq_real,
  output logic [DATA_WIDTH-1:0] yq_imag,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  localparam int PW = DATA_WIDTH + TW_WIDTH;
  localparam int XW = DATA_WIDTH + TW_FRAC;
  localparam int SW = DATA_WIDTH + TW_WIDTH + 2;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic                 v1, inv1, scl1;
  logic [TAG_WIDTH-1:0] tag1;
  logic signed [PW-1:0] rr1, ii1, ri1, ir1;
  logic signed [XW-1:0] xr1, xi1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; inv1 <= 1'b0; scl1 <= 1'b0; tag1 <= '0;
      rr1 <= '0; ii1 <= '0; ri1 <= '0; ir1 <= '0; xr1 <= '0; xi1 <= '0;
    end else if (adv) begin
      v1   <= in_valid & in_ready;
      inv1 <= inverse;
      scl1 <= scale;
      tag1 <= in_tag;
      rr1  <= PW'($signed(xq_real)) * PW'($signed(factor_real));
      ii1  <= PW'($signed(xq_imag)) * PW'($signed(factor_imag));
      ri1  <= PW'($signed(xq_real)) * PW'($signed(factor_imag));
      ir1  <= PW'($signed(xq_imag)) * PW'($signed(factor_real));
      xr1  <= {xp_real, {TW_FRAC{1'b0}}};
      xi1  <= {xp_imag, {TW_FRAC{1'b0}}};
    end
  end

  // Inverse mode conjugates the twiddle by swapping the cross-term signs here.
  logic signed [SW-1:0] mr, mi, xr_e, xi_e;
  always_comb begin
    xr_e = SW'(xr1);
    xi_e = SW'(xi1);
    if (inv1) begin
      mr = SW'(rr1) + SW'(ii1);
      mi = SW'(ir1) - SW'(ri1);
    end else begin
      mr = SW'(rr1) - SW'(ii1);
      mi = SW'(ri1) + SW'(ir1);
    end
  end

  logic                 v2, scl2;
  logic [TAG_WIDTH-1:0] tag2;
  logic [SW-1:0]        pr2, pi2, qr2, qi2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; scl2 <= 1'b0; tag2 <= '0;
      pr2 <= '0; pi2 <= '0; qr2 <= '0; qi2 <= '0;
    end else if (adv) begin
      v2   <= v1;
      scl2 <= scl1;
      tag2 <= tag1;
      pr2  <= xr_e + mr;
      qr2  <= xr_e - mr;
      pi2  <= xi_e + mi;
      qi2  <= xi_e - mi;
    end
  end

  logic [DATA_WIDTH-1:0] rpr, rpi, rqr, rqi;
  logic [3:0]            ovf4;

  fft_round_sat #(.IN_W(SW), .OUT_W(DATA_WIDTH), .FRAC(TW_FRAC)) u_rs_pr (
    .sum(pr2), .scale(scl2), .result(rpr), .ovf(ovf4[0]));
  fft_round_sat #(.IN_W(SW), .OUT_W(DATA_WIDTH), .FRAC(TW_FRAC)) u_rs_pi (
    .sum(pi2), .scale(scl2), .result(rpi), .ovf(ovf4[1]));
  fft_round_sat #(.IN_W(SW), .OUT_W(DATA_WIDTH), .FRAC(TW_FRAC)) u_rs_qr (
    .sum(qr2), .scale(scl2), .result(rqr), .ovf(ovf4[2]));
  fft_round_sat #(.IN_W(SW), .OUT_W(DATA_WIDTH), .FRAC(TW_FRAC)) u_rs_qi (
    .sum(qi2), .scale(scl2), .result(rqi), .ovf(ovf4[3]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0; out_tag <= '0;
      yp_real <= '0; yp_imag <= '0; yq_real <= '0; yq_imag <= '0;
    end else if (adv) begin
      out_valid <= v2;
      out_tag   <= tag2;
      yp_real   <= rpr;
      yp_imag   <= rpi;
      yq_real   <= rqr;
      yq_imag   <= rqi;
    end
  end

  // A clamp landing in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_sticky <= 1'b0;
    else if (adv && v2 && (|ovf4))
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// tb/tb_butterfly_r2_pipe.sv - directed self-checking bench for butterfly_r2_pipe
module tb_butterfly_r2_pipe;

  logic        clk, rst_n;
  logic        in_valid, in_ready, inverse, scale, out_valid, out_ready;
  logic        ovf_sticky, ovf_clr;
  logic [9:0]  in_tag, out_tag;
  logic [15:0] xp_real, xp_imag, xq_real, xq_imag;
  logic [14:0] factor_real, factor_imag;
  logic [15:0] yp_real, yp_imag, yq_real, yq_imag;

  int n_vec = 0;
  int n_err = 0;

  butterfly_r2_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inverse(inverse), .scale(scale), .in_tag(in_tag),
    .xp_real(xp_real), .xp_imag(xp_imag), .xq_real(xq_real), .xq_imag(xq_imag),
    .factor_real(factor_real), .factor_imag(factor_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .yp_real(yp_real), .yp_imag(yp_imag), .yq_real(yq_real), .yq_imag(yq_imag),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic chk_y(input string name, input int epr, input int epi, input int eqr, input int eqi);
    chk({name, "_yp_real"}, $signed(yp_real), epr);
    chk({name, "_yp_imag"}, $signed(yp_imag), epi);
    chk({name, "_yq_real"}, $signed(yq_real), eqr);
    chk({name, "_yq_imag"}, $signed(yq_imag), eqi);
  endtask

  task automatic drive(input int xpr, input int xpi, input int xqr, input int xqi,
                       input int wr, input int wi, input logic inv, input logic scl,
                       input logic [9:0] tag);
    xp_real = 16'(xpr); xp_imag = 16'(xpi);
    xq_real = 16'(xqr); xq_imag = 16'(xqi);
    factor_real = 15'(wr); factor_imag = 15'(wi);
    inverse = inv; scale = scl; in_tag = tag;
  endtask

  // Single accept into an idle pipe; returns at the negedge where out_valid rises.
  task automatic run_one(input string name, input int xpr, input int xpi, input int xqr,
                         input int xqi, input int wr, input int wi, input logic inv,
                         input logic scl, input logic [9:0] tag);
    int lat;
    @(negedge clk);
    drive(xpr, xpi, xqr, xqi, wr, wi, inv, scl, tag);
    in_valid = 1'b1;
    #1;
    chk({name, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, 3);
    chk({name, "_out_tag"}, out_tag, tag);
  endtask

  logic [9:0]  bp_tag [20];
  logic [73:0] exp_q [$];
  logic [73:0] snap, cur, e;
  int sent, got;
  int U;

  initial begin
    U = fft_pkg::TW_UNITY;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 10'd0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_yp_real", yp_real, 0);
    chk("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    run_one("ident", 100, 20, 50, -10, U, 0, 1'b0, 1'b0, 10'h2a5);
    chk_y("ident", 150, 10, 50, 30);

    run_one("negj_fwd", 0, 0, 1000, 0, 0, -U, 1'b0, 1'b0, 10'h011);
    chk_y("negj_fwd", 0, -1000, 0, 1000);
    run_one("negj_inv", 0, 0, 1000, 0, 0, -U, 1'b1, 1'b0, 10'h3ff);
    chk_y("negj_inv", 0, 1000, 0, -1000);

    run_one("sat", 30000, 0, 30000, 0, U, 0, 1'b0, 1'b0, 10'h001);
    chk("sat_yp_real", $signed(yp_real), fft_pkg::SAT_MAX);
    chk("sat_yq_real", $signed(yq_real), 0);
    chk("sat_ovf", ovf_sticky, 1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    #1;
    chk("ovf_cleared", ovf_sticky, 0);
    run_one("sat_scaled", 30000, 0, 30000, 0, U, 0, 1'b0, 1'b1, 10'h002);
    chk_y("sat_scaled", 30000, 0, 0, 0);
    chk("sat_scaled_ovf", ovf_sticky, 0);

    run_one("rnd_p3", 3, 0, 0, 0, U, 0, 1'b0, 1'b1, 10'h003);
    chk_y("rnd_p3", 2, 0, 2, 0);
    run_one("rnd_m3", -3, 0, 0, 0, U, 0, 1'b0, 1'b1, 10'h004);
    chk_y("rnd_m3", -1, 0, -1, 0);
    run_one("rnd_min", -32768, 0, 0, 0, U, 0, 1'b0, 1'b1, 10'h005);
    chk_y("rnd_min", -16384, 0, -16384, 0);
    chk("rnd_ovf", ovf_sticky, 0);

    // Twiddle -unity against most-negative xq; clear held high so set must win.
    ovf_clr = 1'b1;
    run_one("wneg", 0, 0, -32768, -32768, -U, 0, 1'b0, 1'b0, 10'h006);
    chk_y("wneg", 32767, 32767, -32768, -32768);
    chk("set_wins_ovf", ovf_sticky, 1);
    @(negedge clk); ovf_clr = 1'b0;
    #1;
    chk("wneg_ovf_cleared", ovf_sticky, 0);
    run_one("wneg_inv", 0, 0, -32768, 0, 0, -U, 1'b1, 1'b1, 10'h007);
    chk_y("wneg_inv", 0, -16384, 0, 16384);
    chk("wneg_inv_ovf", ovf_sticky, 0);

    // Backpressure stream: 20 accepts, out_ready low for 5 cycles mid-stream.
    for (int i = 0; i < 20; i++) bp_tag[i] = 10'($urandom);
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 8 && cyc < 13);
      if (sent < 20) begin
        drive(sent * 100, -sent, sent, 2 * sent, U, 0, 1'b0, 1'b0, bp_tag[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      cur = {out_tag, yp_real, yp_imag, yq_real, yq_imag};
      if (cyc == 8) begin
        chk("bp_out_valid_stall", out_valid, 1);
        chk("bp_in_ready_low", in_ready, 0);
        snap = cur;
      end else if (cyc > 8 && cyc < 13) begin
        chk("bp_hold_stable", cur, snap);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({bp_tag[sent], 16'(sent * 101), 16'(sent), 16'(sent * 99), 16'(-3 * sent)});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bp_result", cur, e);
        end else begin
          chk("bp_unexpected_output", 1, 0);
        end
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", got, 20);
    @(negedge clk);
    chk("bp_no_extra", out_valid, 0);

    // Reset with three butterflies in flight; the oldest one saturates.
    @(negedge clk);
    drive(30000, 0, 30000, 0, U, 0, 1'b0, 1'b0, 10'h100);
    in_valid = 1'b1;
    @(negedge clk);
    drive(1, 1, 1, 1, U, 0, 1'b0, 1'b0, 10'h101);
    @(negedge clk);
    drive(2, 2, 2, 2, U, 0, 1'b0, 1'b0, 10'h102);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_ovf", ovf_sticky, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ovf", ovf_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one("post_rst", -500, 700, 200, -300, U, 0, 1'b0, 1'b0, 10'h0f0);
    chk_y("post_rst", -300, 400, -700, 1000);
    chk("post_rst_ovf", ovf_sticky, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
